// File: rtl/vram_arbiter_if.sv
// Bundle of host, video-fetch and RAM-side signals around the VRAM arbiter.
// The arbiter connects via the slave modport; requesters and the RAM model use master.
interface vram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_W-1:0]     host_addr;
    logic [DATA_W-1:0]     host_wdata;
    logic [DATA_W/8-1:0]   host_wstrb;
    logic                  host_gnt;
    logic                  host_done;
    logic [DATA_W-1:0]     host_rdata;
    logic                  host_err;

    logic                  vid_req;
    logic [ADDR_W-1:0]     vid_addr;
    logic                  vid_gnt;
    logic                  vid_rvalid;
    logic [DATA_W-1:0]     vid_rdata;

    logic                  ram_en;
    logic [DATA_W/8-1:0]   ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata, host_wstrb,
        input  vid_req, vid_addr, ram_rdata,
        output host_gnt, host_done, host_rdata, host_err,
        output vid_gnt, vid_rvalid, vid_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata, host_wstrb,
        output vid_req, vid_addr, ram_rdata,
        input  host_gnt, host_done, host_rdata, host_err,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port character-VRAM arbiter: video fetch has fixed priority, host gets idle slots.
// Define VRAM_ARB_STARVE_EN to let a starved host steal one slot after STARVE_MAX losses.
module vram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 600,
    parameter int STARVE_MAX = 15
) (
    input  logic           axi_aclk,
    input  logic           axi_aresetn,
    vram_arbiter_if.slave  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    // state | meaning
    // IDLE  | waiting for host_req
    // PEND  | host request captured, waiting for a slot video does not own
    // RD    | host read issued, RAM data arrives this cycle
    // DONE  | host_done pulse with err/rdata
    typedef enum logic [1:0] {IDLE, PEND, RD, DONE} state_t;

    state_t              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                host_done_q;
    logic                host_err_q;
    logic [DATA_W-1:0]   host_rdata_q;

    logic                vid_v1_q;
    logic                vid_oor1_q;
    logic                vid_rvalid_q;
    logic [DATA_W-1:0]   vid_rdata_q;

    logic                starve_win;
    logic                vid_gnt_w;
    logic                vid_in_range;
    logic                host_in_range;
    logic                host_issue;

    assign vid_gnt_w     = axi_aresetn & bus.vid_req & ~starve_win;
    assign vid_in_range  = {1'b0, bus.vid_addr} < DEPTH_X;
    assign host_in_range = {1'b0, bus.host_addr} < DEPTH_X;
    assign host_issue    = (state_q == PEND) & ~vid_gnt_w;

`ifdef VRAM_ARB_STARVE_EN
    localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 4) ? $clog2(STARVE_MAX + 1) : 4;
    logic [CNT_W-1:0] starve_cnt_q;

    assign starve_win = (state_q == PEND) && (starve_cnt_q == CNT_W'(STARVE_MAX));

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            starve_cnt_q <= '0;
        end else if (state_q == PEND && vid_gnt_w) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_q <= '0;
        end
    end
`else
    assign starve_win = 1'b0;
`endif

    // Host issue and video grant are mutually exclusive, so a plain priority mux suffices.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = '0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (host_issue) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = we_q ? wstrb_q : '0;
            bus.ram_addr  = addr_q;
            bus.ram_wdata = wdata_q;
        end else if (vid_gnt_w && vid_in_range) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.vid_addr;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            host_done_q  <= 1'b0;
            host_err_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            host_done_q <= 1'b0;
            host_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.host_req) begin
                        we_q    <= bus.host_we;
                        addr_q  <= bus.host_addr;
                        wdata_q <= bus.host_wdata;
                        wstrb_q <= bus.host_wstrb;
                        if (host_in_range) begin
                            state_q <= PEND;
                        end else begin
                            state_q      <= DONE;
                            host_done_q  <= 1'b1;
                            host_err_q   <= 1'b1;
                            host_rdata_q <= '0;
                        end
                    end
                end
                PEND: begin
                    if (!vid_gnt_w) begin
                        if (we_q) begin
                            state_q      <= DONE;
                            host_done_q  <= 1'b1;
                            host_rdata_q <= '0;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    host_rdata_q <= bus.ram_rdata;
                    host_done_q  <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-stage video return: grant -> RAM access -> registered data.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            vid_v1_q     <= 1'b0;
            vid_oor1_q   <= 1'b0;
            vid_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
        end else begin
            vid_v1_q     <= vid_gnt_w;
            vid_oor1_q   <= ~vid_in_range;
            vid_rvalid_q <= vid_v1_q;
            if (vid_v1_q) begin
                vid_rdata_q <= vid_oor1_q ? '0 : bus.ram_rdata;
            end
        end
    end

    assign bus.host_gnt   = axi_aresetn & (state_q == IDLE) & bus.host_req;
    assign bus.host_done  = host_done_q;
    assign bus.host_err   = host_err_q;
    assign bus.host_rdata = host_rdata_q;
    assign bus.vid_gnt    = vid_gnt_w;
    assign bus.vid_rvalid = vid_rvalid_q;
    assign bus.vid_rdata  = vid_rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model built from the arbitration rules and a word array.
module tb_vram_arbiter;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 600;
    localparam int STARVE_MAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_load = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus.slave)
    );

    logic [31:0] seed;
    logic [31:0] ram_mem [0:1023];
    logic [31:0] ref_mem [0:1023];

    function automatic logic [31:0] pat(input int i);
        return seed ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    // Block RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= pat(i);
        end else if (bus.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          cyc_n = 0;
    int          vmode = 0;
    bit          vp_v [2];
    logic [31:0] vp_d [2];
    bit          h_busy, h_pend, h_we, h_exp_err;
    int          lost, h_done_cyc, gnt_cyc;
    logic [9:0]  h_addr;
    logic [31:0] h_wdata, h_exp_rdata;
    logic [3:0]  h_wstrb;
    int          n_gnt, n_done_model, n_done_obs, obs_done_cyc, vg_drop;
    logic [31:0] obs_rdata;
    logic        obs_err;

    task automatic model_reset();
        h_busy = 0; h_pend = 0; lost = 0; h_done_cyc = -1;
        vp_v[0] = 0; vp_v[1] = 0; vp_d[0] = 0; vp_d[1] = 0;
    endtask

    // One clock: check outputs at the falling edge, then drive video after the rising edge.
    task automatic cyc();
        bit exp_vg, issue, exp_en, v_in, exp_gnt;
        logic [3:0] exp_we;
        logic [9:0] exp_addr;
        @(negedge clk);
        v_in   = int'(bus.vid_addr) < DEPTH;
        exp_vg = bus.vid_req;
`ifdef VRAM_ARB_STARVE_EN
        if (h_pend && lost == STARVE_MAX) exp_vg = 1'b0;
`endif
        chk("vid_gnt", 32'(bus.vid_gnt), 32'(exp_vg));
        if (bus.vid_req && !bus.vid_gnt) vg_drop++;
        issue = h_pend && !exp_vg;
        exp_en = 0; exp_we = 4'h0; exp_addr = 10'd0;
        if (issue) begin
            exp_en = 1; exp_we = h_we ? h_wstrb : 4'h0; exp_addr = h_addr;
        end else if (exp_vg && v_in) begin
            exp_en = 1; exp_addr = bus.vid_addr;
        end
        chk("ram_en", 32'(bus.ram_en), 32'(exp_en));
        if (exp_en) begin
            chk("ram_we", 32'(bus.ram_we), 32'(exp_we));
            chk("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
        end
        if (issue && h_we) chk("ram_wdata", bus.ram_wdata, h_wdata);
        chk("vid_rvalid", 32'(bus.vid_rvalid), 32'(vp_v[1]));
        if (vp_v[1]) chk("vid_rdata", bus.vid_rdata, vp_d[1]);
        vp_v[1] = vp_v[0]; vp_d[1] = vp_d[0];
        vp_v[0] = exp_vg;
        vp_d[0] = v_in ? ref_mem[bus.vid_addr] : 32'h0;
        if (bus.host_done === 1'b1) begin
            obs_done_cyc = cyc_n; obs_rdata = bus.host_rdata; obs_err = bus.host_err; n_done_obs++;
        end
        chk("host_done", 32'(bus.host_done), 32'(cyc_n == h_done_cyc));
        if (cyc_n == h_done_cyc) begin
            chk("host_err", 32'(bus.host_err), 32'(h_exp_err));
            chk("host_rdata", bus.host_rdata, h_exp_rdata);
            n_done_model++;
        end
        if (issue) begin
            if (h_we) begin
                for (int b = 0; b < 4; b++)
                    if (h_wstrb[b]) ref_mem[h_addr][8*b +: 8] = h_wdata[8*b +: 8];
            end else begin
                h_exp_rdata = ref_mem[h_addr];
            end
            h_pend = 0; lost = 0;
            h_done_cyc = cyc_n + (h_we ? 1 : 2);
        end else if (h_pend && exp_vg) begin
            lost++;
        end
        exp_gnt = bus.host_req && !h_busy;
        chk("host_gnt", 32'(bus.host_gnt), 32'(exp_gnt));
        if (cyc_n == h_done_cyc) h_busy = 0;
        if (exp_gnt) begin
            h_we = bus.host_we; h_addr = bus.host_addr;
            h_wdata = bus.host_wdata; h_wstrb = bus.host_wstrb;
            h_busy = 1; gnt_cyc = cyc_n; n_gnt++; h_exp_rdata = 32'h0;
            if (int'(bus.host_addr) >= DEPTH) begin
                h_exp_err = 1; h_done_cyc = cyc_n + 1;
            end else begin
                h_exp_err = 0; h_pend = 1; h_done_cyc = -1;
            end
        end
        cyc_n++;
        @(posedge clk);
        #1;
        case (vmode)
            0: bus.vid_req = 1'b0;
            1: begin
                if (bus.vid_req && exp_vg) bus.vid_addr = bus.vid_addr + 10'd1;
                bus.vid_req = 1'b1;
            end
            2: begin
                if (bus.vid_req && exp_vg) begin
                    bus.vid_addr = bus.vid_addr + 10'd1;
                    bus.vid_req  = 1'b0;
                end else if (!bus.vid_req) begin
                    bus.vid_req = 1'b1;
                end
            end
            3: if (!(bus.vid_req && !exp_vg)) begin
                bus.vid_req  = ($urandom_range(0, 2) == 0);
                bus.vid_addr = 10'($urandom_range(0, 650));
            end
            default: bus.vid_req = 1'b0;
        endcase
    endtask

    task automatic host_start(input bit we, input int addr, input logic [31:0] wd,
                              input logic [3:0] ws, input bit hold);
        int g0;
        g0 = n_gnt;
        bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = 10'(addr);
        bus.host_wdata = wd; bus.host_wstrb = ws;
        for (int i = 0; i < 20 && n_gnt == g0; i++) cyc();
        chk("gnt_wait", 32'(n_gnt - g0), 32'd1);
        if (!hold) bus.host_req = 1'b0;
    endtask

    task automatic host_wait(input int budget, output int lat);
        int d0;
        d0 = n_done_model;
        for (int i = 0; i < budget && n_done_model == d0; i++) cyc();
        chk("done_wait", 32'(n_done_model - d0), 32'd1);
        lat = obs_done_cyc - gnt_cyc;
    endtask

    task automatic host_op(input bit we, input int addr, input logic [31:0] wd,
                           input logic [3:0] ws, output int lat);
        host_start(we, addr, wd, ws, 1'b0);
        host_wait(300, lat);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_host_gnt",   32'(bus.host_gnt),   32'd0);
        chk("rst_host_done",  32'(bus.host_done),  32'd0);
        chk("rst_host_err",   32'(bus.host_err),   32'd0);
        chk("rst_host_rdata", bus.host_rdata,      32'd0);
        chk("rst_vid_gnt",    32'(bus.vid_gnt),    32'd0);
        chk("rst_vid_rvalid", 32'(bus.vid_rvalid), 32'd0);
        chk("rst_vid_rdata",  bus.vid_rdata,       32'd0);
        chk("rst_ram_en",     32'(bus.ram_en),     32'd0);
        chk("rst_ram_we",     32'(bus.ram_we),     32'd0);
        chk("rst_ram_addr",   32'(bus.ram_addr),   32'd0);
        chk("rst_ram_wdata",  bus.ram_wdata,       32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0;
        seed = $urandom;
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0;
        bus.host_wdata = 0; bus.host_wstrb = 0;
        bus.vid_req = 0; bus.vid_addr = 0;
        n_gnt = 0; n_done_model = 0; n_done_obs = 0; obs_done_cyc = -1; vg_drop = 0;
        obs_rdata = 0; obs_err = 0; gnt_cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        mem_load = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // write then read back, no video
        host_op(1, 3, 32'hA5A5_0001, 4'hF, lat);
        chk("wr3_lat", 32'(lat), 32'd2);
        host_op(0, 3, 32'h0, 4'h0, lat);
        chk("rd3_lat", 32'(lat), 32'd3);
        chk("rd3_data", obs_rdata, 32'hA5A5_0001);
        chk("rd3_err", 32'(obs_err), 32'd0);

        // byte strobes
        host_op(1, 7, 32'hFFFF_FFFF, 4'hF, lat);
        host_op(1, 7, 32'h0000_1200, 4'b0010, lat);
        host_op(0, 7, 32'h0, 4'h0, lat);
        chk("rd7_merge", obs_rdata, 32'hFFFF_12FF);

        // zero-strobe write changes nothing
        host_op(1, 9, 32'hDEAD_BEEF, 4'h0, lat);
        chk("wr9_lat", 32'(lat), 32'd2);
        host_op(0, 9, 32'h0, 4'h0, lat);
        chk("rd9_keep", obs_rdata, pat(9));

        // out of range
        host_op(0, 600, 32'h0, 4'h0, lat);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_err", 32'(obs_err), 32'd1);
        chk("oor_rdata", obs_rdata, 32'd0);

        // reset while the read sits in RD
        host_start(0, 40, 32'h0, 4'h0, 1'b0);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        d0 = n_done_obs;
        repeat (5) cyc();
        chk("no_done_after_reset", 32'(n_done_obs - d0), 32'd0);
        host_op(0, 5, 32'h0, 4'h0, lat);
        chk("rd5_after_reset", obs_rdata, pat(5));
        chk("rd5_lat", 32'(lat), 32'd3);

        // held host_req is accepted again right after done
        host_start(0, 11, 32'h0, 4'h0, 1'b1);
        host_wait(50, lat);
        d0 = obs_done_cyc;
        host_start(0, 12, 32'h0, 4'h0, 1'b0);
        chk("reaccept_gap", 32'(gnt_cyc - d0), 32'd1);
        host_wait(50, lat);
        chk("rd12_data", obs_rdata, pat(12));

        // continuous video with a pending host read
        bus.vid_req = 1'b1; bus.vid_addr = 10'd0; vmode = 1; vg_drop = 0;
        host_start(0, 50, 32'h0, 4'h0, 1'b0);
`ifdef VRAM_ARB_STARVE_EN
        host_wait(100, lat);
        chk("starve_lat", 32'(lat), 32'd18);
        chk("starve_drops", 32'(vg_drop), 32'd1);
`else
        d0 = n_done_obs;
        repeat (40) cyc();
        chk("starved_no_done", 32'(n_done_obs - d0), 32'd0);
        chk("starved_no_drop", 32'(vg_drop), 32'd0);
        vmode = 0;
        host_wait(20, lat);
`endif
        chk("rd50_data", obs_rdata, pat(50));
        vmode = 0;
        repeat (4) cyc();

        // alternating video with a host write
        bus.vid_req = 1'b1; bus.vid_addr = 10'd100; vmode = 2;
        host_op(1, 20, 32'h1234_5678, 4'hF, lat);
        vmode = 0;
        repeat (4) cyc();
        host_op(0, 20, 32'h0, 4'h0, lat);
        chk("rd20_data", obs_rdata, 32'h1234_5678);

        // randomized traffic
        vmode = 3;
        for (int k = 0; k < 40; k++) begin
            host_op($urandom_range(0, 1) == 1, $urandom_range(0, 700), $urandom,
                    4'($urandom_range(0, 15)), lat);
            repeat ($urandom_range(0, 2)) cyc();
        end
        vmode = 0;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
